// File: rtl/vnu_layer_control_if.sv
// rtl/vnu_layer_control_if.sv - CNU <-> VNU layer-control handshake bundle
//
// Groups the CNU-side strobes/qualifiers and the VNU control status lines.
// master : CNU side (drives fsm_en, c2v_mem_we, syn_valid, syn_zero)
// slave  : VNU layer control unit (drives layer_finish, vnu_update_pend,
//          vnu_rd, v2c_mem_we, termination, decode_ok, err_ovf,
//          layer_idx, iter_idx, state)
interface vnu_layer_control_if #(
    parameter int LAYER_NUM     = 3,
    parameter int MAX_ITER      = 10,
    parameter int FSM_STATE_NUM = 6
);
    localparam int LAYER_W = $clog2(LAYER_NUM);
    localparam int ITER_W  = $clog2(MAX_ITER + 1);
    localparam int STATE_W = $clog2(FSM_STATE_NUM);

    logic               fsm_en;
    logic               c2v_mem_we;
    logic               syn_valid;
    logic               syn_zero;
    logic               layer_finish;
    logic               vnu_update_pend;
    logic               vnu_rd;
    logic               v2c_mem_we;
    logic               termination;
    logic               decode_ok;
    logic               err_ovf;
    logic [LAYER_W-1:0] layer_idx;
    logic [ITER_W-1:0]  iter_idx;
    logic [STATE_W-1:0] state;

    modport master (
        output fsm_en, c2v_mem_we, syn_valid, syn_zero,
        input  layer_finish, vnu_update_pend, vnu_rd, v2c_mem_we,
        input  termination, decode_ok, err_ovf, layer_idx, iter_idx, state
    );

    modport slave (
        input  fsm_en, c2v_mem_we, syn_valid, syn_zero,
        output layer_finish, vnu_update_pend, vnu_rd, v2c_mem_we,
        output termination, decode_ok, err_ovf, layer_idx, iter_idx, state
    );
endinterface

// File: rtl/vnu_layer_control_unit.sv
// rtl/vnu_layer_control_unit.sv - VNU layer sequencer, layer/iteration counters and early termination
//
// Ports:
//   read_clk : system clock
//   rstn     : asynchronous active-low reset
//   vif      : vnu_layer_control_if.slave
//              in : fsm_en, c2v_mem_we, syn_valid, syn_zero
//              out: layer_finish, vnu_update_pend, vnu_rd, v2c_mem_we,
//                   termination, decode_ok, err_ovf, layer_idx, iter_idx, state
module vnu_layer_control_unit #(
    parameter int LAYER_NUM          = 3,
    parameter int MAX_ITER           = 10,
    parameter int MEM_RD_LEVEL       = 2,
    parameter int VNU_PIPELINE_LEVEL = 3,
    parameter int FSM_STATE_NUM      = 6
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    vnu_layer_control_if.slave   vif
);
    localparam int LAYER_W = $clog2(LAYER_NUM);
    localparam int ITER_W  = $clog2(MAX_ITER + 1);
    localparam int STATE_W = $clog2(FSM_STATE_NUM);
    localparam int CNT_MAX = (MEM_RD_LEVEL > VNU_PIPELINE_LEVEL) ? MEM_RD_LEVEL : VNU_PIPELINE_LEVEL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [STATE_W-1:0] V_IDLE      = STATE_W'(0);
    localparam logic [STATE_W-1:0] V_FETCH     = STATE_W'(1);
    localparam logic [STATE_W-1:0] V_PIPE      = STATE_W'(2);
    localparam logic [STATE_W-1:0] V_WB        = STATE_W'(3);
    localparam logic [STATE_W-1:0] V_SYN_CHECK = STATE_W'(4);
    localparam logic [STATE_W-1:0] V_TERM      = STATE_W'(5);

    localparam logic [CNT_W-1:0]   FETCH_LAST  = CNT_W'(MEM_RD_LEVEL - 1);
    localparam logic [CNT_W-1:0]   PIPE_LAST   = CNT_W'(VNU_PIPELINE_LEVEL - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST  = LAYER_W'(LAYER_NUM - 1);
    localparam logic [ITER_W-1:0]  ITER_LAST   = ITER_W'(MAX_ITER - 1);

    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LAYER_W-1:0] layer_q;
    logic [ITER_W-1:0]  iter_q;
    logic               layer_finish_q;
    logic               decode_ok_q;
    logic               err_ovf_q;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= V_IDLE;
            cnt_q          <= '0;
            layer_q        <= '0;
            iter_q         <= '0;
            layer_finish_q <= 1'b0;
            decode_ok_q    <= 1'b0;
            err_ovf_q      <= 1'b0;
        end else if (!vif.fsm_en) begin
            // decode_ok and err_ovf deliberately survive an fsm_en drop
            state_q        <= V_IDLE;
            cnt_q          <= '0;
            layer_q        <= '0;
            iter_q         <= '0;
            layer_finish_q <= 1'b0;
        end else begin
            layer_finish_q <= 1'b0;
            // A write-back from the CNU while a layer is still in flight is dropped
            if (vif.c2v_mem_we && (state_q != V_IDLE)) begin
                err_ovf_q <= 1'b1;
            end
            case (state_q)
                V_IDLE: begin
                    if (vif.c2v_mem_we) begin
                        // Release the CNU immediately so its next fetch overlaps this update
                        state_q        <= V_FETCH;
                        cnt_q          <= '0;
                        layer_finish_q <= 1'b1;
                    end
                end
                V_FETCH: begin
                    if (cnt_q == FETCH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= V_PIPE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                V_PIPE: begin
                    if (cnt_q == PIPE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= V_WB;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                V_WB: begin
                    if (layer_q == LAYER_LAST) begin
                        state_q <= V_SYN_CHECK;
                    end else begin
                        layer_q <= layer_q + LAYER_W'(1);
                        state_q <= V_IDLE;
                    end
                end
                V_SYN_CHECK: begin
                    if (vif.syn_valid) begin
                        if (vif.syn_zero) begin
                            decode_ok_q <= 1'b1;
                            state_q     <= V_TERM;
                        end else if (iter_q == ITER_LAST) begin
                            decode_ok_q <= 1'b0;
                            state_q     <= V_TERM;
                        end else begin
                            iter_q  <= iter_q + ITER_W'(1);
                            layer_q <= '0;
                            state_q <= V_IDLE;
                        end
                    end
                end
                V_TERM: begin
                    layer_q <= '0;
                    iter_q  <= '0;
                    state_q <= V_IDLE;
                end
                default: begin
                    state_q <= V_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset clears them at once
    assign vif.vnu_update_pend = (state_q != V_IDLE);
    assign vif.vnu_rd          = (state_q == V_FETCH) || (state_q == V_PIPE);
    assign vif.v2c_mem_we      = (state_q == V_WB);
    assign vif.termination     = (state_q == V_TERM);
    assign vif.layer_finish    = layer_finish_q;
    assign vif.decode_ok       = decode_ok_q;
    assign vif.err_ovf         = err_ovf_q;
    assign vif.layer_idx       = layer_q;
    assign vif.iter_idx        = iter_q;
    assign vif.state           = state_q;
endmodule

// File: tb/tb_vnu_layer_control_unit.sv
// tb/tb_vnu_layer_control_unit.sv - directed bench for vnu_layer_control_unit
module tb_vnu_layer_control_unit;
    logic read_clk = 1'b0;
    logic rstn     = 1'b0;

    always #5 read_clk = ~read_clk;

    vnu_layer_control_if #(.LAYER_NUM(3), .MAX_ITER(10), .FSM_STATE_NUM(6)) vif ();

    vnu_layer_control_unit #(
        .LAYER_NUM(3), .MAX_ITER(10), .MEM_RD_LEVEL(2),
        .VNU_PIPELINE_LEVEL(3), .FSM_STATE_NUM(6)
    ) dut (
        .read_clk (read_clk),
        .rstn     (rstn),
        .vif      (vif)
    );

    typedef struct {
        logic        c2v;
        logic        sv;
        logic        sz;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks  = 0;
    int   errors  = 0;
    int   v2c_cnt = 0;
    int   term_cnt = 0;

    // {layer_finish, pend, vnu_rd, v2c_mem_we, termination, decode_ok, err_ovf, state, layer, iter}
    function automatic logic [15:0] mk(input logic lf, input logic pend, input logic rd,
                                       input logic v2c, input logic term, input logic dok,
                                       input logic ovf, input logic [2:0] st,
                                       input logic [1:0] lay, input logic [3:0] it);
        return {lf, pend, rd, v2c, term, dok, ovf, st, lay, it};
    endfunction

    function automatic logic [15:0] outs();
        return {vif.layer_finish, vif.vnu_update_pend, vif.vnu_rd, vif.v2c_mem_we,
                vif.termination, vif.decode_ok, vif.err_ovf, vif.state,
                vif.layer_idx, vif.iter_idx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge read_clk);
        #1;
        if (vif.v2c_mem_we)  v2c_cnt++;
        if (vif.termination) term_cnt++;
    endtask

    task automatic push(input logic c2v, input logic sv, input logic sz, input logic [15:0] e);
        vec_t v;
        v.c2v = c2v; v.sv = sv; v.sz = sz; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic do_layer();
        logic done;
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vif.state == 3'd0 || vif.state == 3'd4) break;
            step();
        end
        done = (vif.state == 3'd0 || vif.state == 3'd4);
        check("layer_done", {31'd0, done}, 32'd1);
    endtask

    task automatic syn_fail();
        vif.syn_valid = 1'b1;
        vif.syn_zero  = 1'b0;
        step();
        vif.syn_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        logic ok;
        vif.fsm_en     = 1'b1;
        vif.c2v_mem_we = 1'b0;
        vif.syn_valid  = 1'b0;
        vif.syn_zero   = 1'b0;
        step();
        step();
        check("reset_state", {16'd0, outs()}, 32'd0);
        rstn = 1'b1;
        step();

        // One full frame: three layers, then syndrome zero two cycles after V_SYN_CHECK entry
        for (int lay = 0; lay < 3; lay++) begin
            push(1, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 3'd1, 2'(lay), 4'd0));
            push(0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 3'd1, 2'(lay), 4'd0));
            for (int k = 0; k < 3; k++)
                push(0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 3'd2, 2'(lay), 4'd0));
            push(0, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 3'd3, 2'(lay), 4'd0));
            if (lay < 2)
                push(0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 2'(lay + 1), 4'd0));
            else
                push(0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 3'd4, 2'd2, 4'd0));
        end
        push(0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 3'd4, 2'd2, 4'd0));
        push(0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 3'd4, 2'd2, 4'd0));
        push(0, 1, 1, mk(0, 1, 0, 0, 1, 1, 0, 3'd5, 2'd2, 4'd0));
        push(0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 4'd0));

        foreach (vecs[i]) begin
            vif.c2v_mem_we = vecs[i].c2v;
            vif.syn_valid  = vecs[i].sv;
            vif.syn_zero   = vecs[i].sz;
            step();
            check($sformatf("vec%0d", i), {16'd0, outs()}, {16'd0, vecs[i].exp});
        end
        vif.c2v_mem_we = 1'b0;
        vif.syn_valid  = 1'b0;
        vif.syn_zero   = 1'b0;

        // Iteration budget exhaustion: syndrome never zero
        v2c_cnt  = 0;
        term_cnt = 0;
        for (int it = 0; it < 10; it++) begin
            for (int l = 0; l < 3; l++) do_layer();
            check("syn_entry_state", {29'd0, vif.state}, 32'd4);
            syn_fail();
            if (it < 9) begin
                check("iter_state", {29'd0, vif.state}, 32'd0);
                check("iter_idx", {28'd0, vif.iter_idx}, 32'(it + 1));
            end else begin
                check("ovf_term", {31'd0, vif.termination}, 32'd1);
                check("v2c_count", 32'(v2c_cnt), 32'd30);
            end
        end
        step();
        check("budget_decode_ok", {31'd0, vif.decode_ok}, 32'd0);
        check("budget_iter_clr", {28'd0, vif.iter_idx}, 32'd0);
        check("budget_term_cnt", 32'(term_cnt), 32'd1);

        // Second c2v_mem_we during V_PIPE: flagged, timing unchanged
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        step();
        step();
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        check("err_ovf_set", {31'd0, vif.err_ovf}, 32'd1);
        check("ovf_pipe_state", {29'd0, vif.state}, 32'd2);
        step();
        step();
        check("ovf_wb_timing", {31'd0, vif.v2c_mem_we}, 32'd1);
        step();
        check("ovf_layer_next", {29'd0, vif.state, vif.layer_idx}, {27'd0, 3'd0, 2'd1});

        // Async reset during V_PIPE of layer 2, iteration 4
        pulse_reset();
        for (int it = 0; it < 4; it++) begin
            for (int l = 0; l < 3; l++) do_layer();
            syn_fail();
        end
        do_layer();
        do_layer();
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        step();
        step();
        check("pre_reset_pos", {25'd0, vif.state, vif.layer_idx, vif.iter_idx}, {25'd0, 3'd2, 2'd2, 4'd4});
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outs", {16'd0, outs()}, 32'd0);
        step();
        rstn = 1'b1;
        term_cnt = 0;
        do_layer();
        check("post_reset_layer", {26'd0, vif.layer_idx, vif.iter_idx}, {26'd0, 2'd1, 4'd0});

        // syn_valid withheld for 50 cycles in V_SYN_CHECK
        do_layer();
        do_layer();
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (vif.state != 3'd4 || !vif.vnu_update_pend) ok = 1'b0;
        end
        check("syn_wait_hold", {31'd0, ok}, 32'd1);
        syn_fail();
        check("syn_wait_resume", {25'd0, vif.state, vif.layer_idx, vif.iter_idx}, {25'd0, 3'd0, 2'd0, 4'd1});

        // fsm_en drop mid-frame aborts without termination; fsm_en beats c2v_mem_we
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        step();
        vif.fsm_en = 1'b0;
        step();
        check("fsm_en_abort", {24'd0, vif.vnu_update_pend, vif.state, vif.layer_idx, vif.iter_idx},
              {24'd0, 1'b0, 3'd0, 2'd0, 4'd0});
        vif.c2v_mem_we = 1'b1;
        step();
        vif.c2v_mem_we = 1'b0;
        check("fsm_en_wins", {28'd0, vif.err_ovf, vif.state}, 32'd0);
        vif.fsm_en = 1'b1;
        step();
        check("no_term_on_abort", 32'(term_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
